gpr_writeback_unit: RTL and testbench

Final pipeline stage that produces the register-file write port consumed by the decode stage: `we_gpr_writeback`, `rd_writeback`, `result_writeback`. Accepts one retiring instruction per handshake from the memory stage. ALU results are forwarded directly. Loads wait for the data-memory response, then have byte/half/word extraction and sign/zero extension applied. Also counts retired instructions and flags misaligned loads.

---
 rtl/gpr_writeback_unit.sv | 144 ++++++++++++++
 tb/tb_gpr_writeback_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : gpr_writeback_unit
// Purpose  : Final pipeline stage. Retires one instruction per handshake from
//            the memory stage and drives the register-file write port. ALU
//            results go straight through. Loads wait for the data-memory
//            response, then get byte/half/word extraction and sign/zero
//            extension. Also counts retired instructions and flags misaligned
//            loads.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready                 - memory-stage handshake
//            in_we_gpr, in_rd, in_result,
//            in_is_load, in_funct3             - retiring instruction
//            dmem_rvalid, dmem_rdata           - load response
//            we_gpr_writeback, rd_writeback,
//            result_writeback                  - register-file write port
//            misaligned_err                    - misaligned-load pulse
//            retired_count                     - retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module gpr_writeback_unit #(
   parameter int XLEN            = 32,
   parameter int GPR_ENCODE_BITS = 5,
   parameter int CNT_W           = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_we_gpr,
   input  logic [GPR_ENCODE_BITS-1:0] in_rd,
   input  logic [XLEN-1:0]            in_result,
   input  logic                       in_is_load,
   input  logic [2:0]                 in_funct3,
   input  logic                       dmem_rvalid,
   input  logic [XLEN-1:0]            dmem_rdata,
   output logic                       we_gpr_writeback,
   output logic [GPR_ENCODE_BITS-1:0] rd_writeback,
   output logic [XLEN-1:0]            result_writeback,
   output logic                       misaligned_err,
   output logic [CNT_W-1:0]           retired_count
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   state_t                       r_state;
   logic [GPR_ENCODE_BITS-1:0]   r_ld_rd;
   logic                         r_ld_we;
   logic [2:0]                   r_ld_funct3;
   logic [1:0]                   r_ld_off;

   logic [7:0]                   w_byte;
   logic [15:0]                  w_half;
   logic [XLEN-1:0]              w_load_data;
   logic                         w_misaligned;
   logic                         w_handshake;

   assign in_ready    = (r_state == IDLE);
   assign w_handshake = in_valid && in_ready;

   // Offset-based lane select; the memory returns the aligned word.
   assign w_byte = dmem_rdata[{r_ld_off, 3'b000} +: 8];
   assign w_half = dmem_rdata[{r_ld_off[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = '0;
      case (r_ld_funct3)
         c_f3_lb:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         c_f3_lbu: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
         c_f3_lh:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
         c_f3_lhu: w_load_data = {{(XLEN-16){1'b0}}, w_half};
         c_f3_lw:  w_load_data = dmem_rdata;
         default:  w_load_data = '0;
      endcase
   end

   always_comb begin
      w_misaligned = 1'b0;
      if ((r_ld_funct3 == c_f3_lh) || (r_ld_funct3 == c_f3_lhu))
         w_misaligned = r_ld_off[0];
      else if (r_ld_funct3 == c_f3_lw)
         w_misaligned = (r_ld_off != 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_ld_rd          <= '0;
         r_ld_we          <= 1'b0;
         r_ld_funct3      <= 3'b000;
         r_ld_off         <= 2'b00;
         we_gpr_writeback <= 1'b0;
         rd_writeback     <= '0;
         result_writeback <= '0;
         misaligned_err   <= 1'b0;
         retired_count    <= '0;
      end else begin
         // Pulses default low; rd/result hold until the next retire.
         we_gpr_writeback <= 1'b0;
         misaligned_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_handshake) begin
                  if (!in_is_load) begin
                     we_gpr_writeback <= in_we_gpr && (in_rd != '0);
                     rd_writeback     <= in_rd;
                     result_writeback <= in_result;
                     retired_count    <= retired_count + CNT_W'(1);
                  end else begin
                     r_ld_rd     <= in_rd;
                     r_ld_we     <= in_we_gpr;
                     r_ld_funct3 <= in_funct3;
                     r_ld_off    <= in_result[1:0];
                     r_state     <= WAIT_LOAD;
                  end
               end
            end
            WAIT_LOAD: begin
               if (dmem_rvalid) begin
                  // Misaligned loads still retire but never write the GPR.
                  we_gpr_writeback <= r_ld_we && (r_ld_rd != '0) && !w_misaligned;
                  rd_writeback     <= r_ld_rd;
                  result_writeback <= w_load_data;
                  misaligned_err   <= w_misaligned;
                  retired_count    <= retired_count + CNT_W'(1);
                  r_state          <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_writeback_unit
// Purpose  : Directed self-checking bench for gpr_writeback_unit. A second
//            instance with a 4-bit counter exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_we_gpr = 1'b0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_result = '0;
   logic        in_is_load = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        we_gpr_writeback;
   logic [4:0]  rd_writeback;
   logic [31:0] result_writeback;
   logic        misaligned_err;
   logic [63:0] retired_count;

   // small-counter instance
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_we;
   logic [4:0]  s_rd;
   logic [31:0] s_result;
   logic        s_mis;
   logic [3:0]  s_count;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_count = '0;

   always #5 clk = ~clk;

   gpr_writeback_unit #(.XLEN(32), .GPR_ENCODE_BITS(5), .CNT_W(64)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_we_gpr(in_we_gpr), .in_rd(in_rd), .in_result(in_result),
      .in_is_load(in_is_load), .in_funct3(in_funct3),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .we_gpr_writeback(we_gpr_writeback), .rd_writeback(rd_writeback),
      .result_writeback(result_writeback), .misaligned_err(misaligned_err),
      .retired_count(retired_count)
   );

   gpr_writeback_unit #(.XLEN(32), .GPR_ENCODE_BITS(5), .CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
      .in_we_gpr(in_we_gpr), .in_rd(in_rd), .in_result(in_result),
      .in_is_load(in_is_load), .in_funct3(in_funct3),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .we_gpr_writeback(s_we), .rd_writeback(s_rd),
      .result_writeback(s_result), .misaligned_err(s_mis),
      .retired_count(s_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Non-load handshake; checks the write port the cycle after.
   task automatic alu_op(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] res);
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b0; in_we_gpr = we; in_rd = rd; in_result = res;
      @(posedge clk); #1;
      exp_count = exp_count + 64'd1;
      check({tag, "_we"}, {63'd0, we_gpr_writeback}, {63'd0, we && (rd != 5'd0)});
      check({tag, "_rd"}, {59'd0, rd_writeback}, {59'd0, rd});
      check({tag, "_data"}, {32'd0, result_writeback}, {32'd0, res});
      check({tag, "_cnt"}, retired_count, exp_count);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Load with a 3-cycle response delay.
   task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_mis);
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_we_gpr = 1'b1; in_rd = rd;
      in_result = addr; in_funct3 = f3;
      @(posedge clk); #1;
      check({tag, "_ready_lo"}, {63'd0, in_ready}, 64'd0);
      check({tag, "_no_early_we"}, {63'd0, we_gpr_writeback}, 64'd0);
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, "_ready_wait"}, {63'd0, in_ready}, 64'd0);
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      @(posedge clk); #1;
      exp_count = exp_count + 64'd1;
      check({tag, "_we"}, {63'd0, we_gpr_writeback}, {63'd0, !exp_mis});
      check({tag, "_mis"}, {63'd0, misaligned_err}, {63'd0, exp_mis});
      if (!exp_mis) begin
         check({tag, "_rd"}, {59'd0, rd_writeback}, {59'd0, rd});
         check({tag, "_data"}, {32'd0, result_writeback}, {32'd0, exp_data});
      end
      check({tag, "_cnt"}, retired_count, exp_count);
      check({tag, "_ready_hi"}, {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      dmem_rvalid = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_we", {63'd0, we_gpr_writeback}, 64'd0);
      check("rst_rd", {59'd0, rd_writeback}, 64'd0);
      check("rst_data", {32'd0, result_writeback}, 64'd0);
      check("rst_mis", {63'd0, misaligned_err}, 64'd0);
      check("rst_cnt", retired_count, 64'd0);
      check("rst_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      alu_op("add", 1'b1, 5'd5, 32'h0000_1234);
      // Next idle cycle: pulse drops, data holds.
      @(posedge clk); #1;
      check("hold_we", {63'd0, we_gpr_writeback}, 64'd0);
      check("hold_data", {32'd0, result_writeback}, 64'h1234);

      alu_op("x0", 1'b1, 5'd0, 32'hFFFF_FFFF);
      alu_op("store", 1'b0, 5'd3, 32'h0000_0040);
      check("cnt_after_store", retired_count, 64'd3);

      // Load extension, rdata = 0x80F0_7F81
      load_op("lb0",  3'b000, 32'h100, 5'd6,  32'h80F0_7F81, 32'hFFFF_FF81, 1'b0);
      load_op("lbu3", 3'b100, 32'h103, 5'd7,  32'h80F0_7F81, 32'h0000_0080, 1'b0);
      load_op("lh2",  3'b001, 32'h102, 5'd8,  32'h80F0_7F81, 32'hFFFF_80F0, 1'b0);
      load_op("lhu0", 3'b101, 32'h100, 5'd9,  32'h80F0_7F81, 32'h0000_7F81, 1'b0);
      load_op("lw",   3'b010, 32'h100, 5'd10, 32'h80F0_7F81, 32'h80F0_7F81, 1'b0);

      // Misaligned
      load_op("lw2_mis", 3'b010, 32'h102, 5'd11, 32'h1122_3344, 32'h0, 1'b1);
      load_op("lh1_mis", 3'b001, 32'h101, 5'd12, 32'h1122_3344, 32'h0, 1'b1);

      // Back-to-back: valid held high for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_is_load = 1'b0; in_we_gpr = 1'b1;
         in_rd = 5'(i + 1); in_result = 32'd100 + 32'(i);
         @(posedge clk); #1;
         exp_count = exp_count + 64'd1;
         check("b2b_we", {63'd0, we_gpr_writeback}, 64'd1);
         check("b2b_data", {32'd0, result_writeback}, 64'd100 + 64'(i));
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_cnt", retired_count, exp_count);

      // Wrap on a 4-bit counter instance (main DUT sees no valid)
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         s_valid = 1'b1; in_is_load = 1'b0; in_we_gpr = 1'b1; in_rd = 5'd1;
         @(posedge clk); #1;
         if (i == 14) check("wrap_all_ones", {60'd0, s_count}, 64'hF);
      end
      check("wrap_zero", {60'd0, s_count}, 64'd0);
      @(negedge clk);
      s_valid = 1'b0;

      // Reset mid-load
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_rd = 5'd4;
      in_result = 32'h200;
      @(posedge clk); #1;
      check("midrst_ready_lo", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_async_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_async_cnt", retired_count, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("midrst_we", {63'd0, we_gpr_writeback}, 64'd0);
      check("midrst_ready", {63'd0, in_ready}, 64'd1);
      check("midrst_cnt", retired_count, 64'd0);
      check("midrst_data", {32'd0, result_writeback}, 64'd0);
      @(negedge clk);
      dmem_rvalid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
